// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-memory access unit for RV32I.
// Checks alignment/funct3, drives a req/ack transaction towards data memory,
// generates byte enables and lane-replicated write data, and returns
// sign- or zero-extended load data. Every output is a flop.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] load_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } state_t;

   // A zero timeout means "wait forever"; the last legal wait cycle index is TIMEOUT_CYCLES-1.
   localparam bit          TO_EN_C   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0] TO_LAST_C = TIMEOUT_CYCLES - 32'd1;

   state_t      state_r, state_s;
   logic [2:0]  f3_r, f3_s;
   logic [1:0]  off_r, off_s;
   logic [31:0] cnt_r, cnt_s;
   logic        busy_s, done_s, fault_s, mem_req_s, mem_we_s;
   logic [31:0] load_data_s, mem_addr_s, mem_wdata_s;
   logic [3:0]  mem_be_s;

   // Legal width/sign code for the direction, and natural alignment for H/W.
   function automatic logic access_ok(input logic st, input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = (off[0] == 1'b0);
         3'b010:  ok = (off == 2'b00);
         3'b100:  ok = !st;
         3'b101:  ok = !st && (off[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-lane enables; BU/HU share encodings with B/H in the low two bits.
   function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate the store operand so that whichever lanes are enabled carry the right bytes.
   function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         2'b10:   w = d;
         default: w = d;
      endcase
      return w;
   endfunction

   // Pick the addressed lane out of the read word and extend it.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rd >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b100:  r = {24'h000000, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b101:  r = {16'h0000, sh[15:0]};
         3'b010:  r = rd;
         default: r = rd;
      endcase
      return r;
   endfunction

   // Next-state and next-output logic; every register holds unless changed below.
   always_comb begin
      state_s     = state_r;
      f3_s        = f3_r;
      off_s       = off_r;
      cnt_s       = cnt_r;
      busy_s      = busy;
      done_s      = done;
      fault_s     = fault;
      load_data_s = load_data;
      mem_req_s   = mem_req;
      mem_we_s    = mem_we;
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
      mem_be_s    = mem_be;
      case (state_r)
         IDLE: begin
            busy_s    = 1'b0;
            done_s    = 1'b0;
            fault_s   = 1'b0;
            mem_req_s = 1'b0;
            if (start) begin
               busy_s = 1'b1;
               if (access_ok(is_store, funct3, addr[1:0])) begin
                  state_s     = REQ;
                  mem_req_s   = 1'b1;
                  mem_we_s    = is_store;
                  mem_addr_s  = {addr[31:2], 2'b00};
                  mem_be_s    = be_gen(funct3, addr[1:0]);
                  mem_wdata_s = wdata_gen(funct3, store_data);
                  f3_s        = funct3;
                  off_s       = addr[1:0];
                  cnt_s       = 32'd0;
               end else begin
                  // Rejected before touching memory.
                  state_s = RESP;
                  done_s  = 1'b1;
                  fault_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_s   = RESP;
               mem_req_s = 1'b0;
               done_s    = 1'b1;
               fault_s   = 1'b0;
               if (!mem_we) begin
                  load_data_s = load_ext(f3_r, off_r, mem_rdata);
               end else begin
                  load_data_s = load_data;
               end
            end else if (TO_EN_C && (cnt_r == TO_LAST_C)) begin
               state_s   = RESP;
               mem_req_s = 1'b0;
               done_s    = 1'b1;
               fault_s   = 1'b1;
            end else begin
               cnt_s = cnt_r + 32'd1;
            end
         end
         RESP: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b0;
            fault_s = 1'b0;
         end
         default: begin
            state_s   = IDLE;
            busy_s    = 1'b0;
            done_s    = 1'b0;
            fault_s   = 1'b0;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         f3_r      <= 3'b000;
         off_r     <= 2'b00;
         cnt_r     <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         load_data <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_be    <= 4'b0000;
      end else begin
         state_r   <= state_s;
         f3_r      <= f3_s;
         off_r     <= off_s;
         cnt_r     <= cnt_s;
         busy      <= busy_s;
         done      <= done_s;
         fault     <= fault_s;
         load_data <= load_data_s;
         mem_req   <= mem_req_s;
         mem_we    <= mem_we_s;
         mem_addr  <= mem_addr_s;
         mem_wdata <= mem_wdata_s;
         mem_be    <= mem_be_s;
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the MEM stage of the RV32I pipeline. It takes the effective address produced by the ALU, the store operand and funct3, then runs a req/ack handshake with data memory. It generates byte enables and lane-shifted write data, and returns sign- or zero-extended load data. While a transaction is open it stalls the pipeline, and it reports misaligned or illegal accesses and memory timeouts as a fault.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles mem_req may wait for mem_ack before fault; 0 disables timeout.
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  MEM stage presents a valid load/store this cycle; accepted only when busy=0.
- is_store  input  1  1=store, 0=load.
- funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- addr  input  32  effective byte address (ALU result).
- store_data  input  32  rs2 value, data in low bits.
- busy  output  1  transaction open; pipeline stalls.
- done  output  1  one-cycle pulse: transaction finished (success or fault).
- fault  output  1  valid with done: misaligned, illegal funct3 or timeout.
- load_data  output  32  extended load result, valid with done on a successful load, held otherwise.
- mem_req  output  1  memory request.
- mem_we  output  1  write request.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-aligned write data.
- mem_be  output  4  byte enables (bit i = byte lane i).
- mem_ack  input  1  memory accepts and completes request this cycle.
- mem_rdata  input  32  read word, valid when mem_ack=1 on a read.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: busy=0, mem_req=0. On start:
  - Check the access: H/HU needs addr[0]=0, W needs addr[1:0]=00. Legal funct3 is 000/001/010/100/101 for loads and 000/001/010 for stores.
  - Bad access: go to RESP with fault=1. No memory request is issued.
  - Good access: register mem_we, mem_addr, mem_be and mem_wdata, load the timeout counter, and go to REQ.
- mem_be: B gives 4'b0001<<addr[1:0]. H gives 4'b0011<<addr[1:0]. W gives 4'b1111.
- mem_wdata: B replicates store_data[7:0] to all lanes. H replicates store_data[15:0] to both halves. W passes store_data through.
- REQ: mem_req=1, and all mem_* outputs are stable until ack.
  - mem_ack=1: for a load, select the lane from mem_rdata, extend it (B/H sign-extend, BU/HU zero-extend) and register it into load_data. Go to RESP with fault=0.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES: go to RESP with fault=1, and load_data is unchanged.
- RESP: done=1 for exactly one cycle, busy=1, then IDLE. The pipeline advances on done.
- mem_ack while not in REQ is ignored.
- start while busy=1 is ignored; there is no queuing.
- Reset values: busy=0, done=0, fault=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, state IDLE.
- Reset mid-transaction: at the first edge with rst_n=0, mem_req drops and no done is produced for the aborted access.

## Timing
- start sampled at edge 0 gives mem_req=1 from edge 1.
- mem_ack first sampled at edge k (k≥1) gives done and load_data at edge k+1. Minimum latency start→done is 2 cycles.
- Fault on access check: done+fault 1 cycle after start, mem_req never asserted.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, and done+fault follows on the next cycle.
- busy=1 from the cycle after start through the done cycle inclusive. A new start is accepted in the cycle after done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ack after 1 cycle -> mem_addr=0x100, mem_be=1111, mem_we=0. done two cycles after start, load_data=0xDEADBEEF, fault=0.
- LB then LBU at addr=0x103, mem_rdata=0x80FF_1234 -> mem_be=1000. LB gives load_data=0xFFFFFF80. LBU gives 0x00000080.
- SH, addr=0x202, store_data=0xAAAA_BEEF -> mem_addr=0x200, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1. done with fault=0 after ack.
- LW at addr=0x101, and funct3=011 at an aligned address -> done+fault one cycle after start, mem_req stays 0, load_data holds its previous value.
- TIMEOUT_CYCLES=4 with mem_ack never asserted -> mem_req high for 4 cycles, then done+fault. A start pulsed during busy is ignored. The next start is accepted afterwards.
- rst_n=0 while in REQ -> next edge: mem_req=0, busy=0, no done. A fresh LW after reset completes normally.
